// File: rtl/img_cap_pkg.sv
//------------------------------------------------------------------------------
// img_cap_pkg
//   Shared definitions for the camera capture path: capture FSM encoding,
//   memory word width, pad byte, default frame geometry and small helpers
//   that build the 32-bit memory word from pixel content.
//
//   No ports (package).
//------------------------------------------------------------------------------
package img_cap_pkg;

    // Capture FSM encoding (2 bits, also visible on the debug state output).
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_ACTIVE = 2'd2,
        S_DRAIN  = 2'd3
    } cap_state_t;

    // Width of one word handed to the frame-buffer write port.
    localparam int PIX_WORD_W = 32;

    // Upper byte of every word; pixels are 24-bit RGB.
    localparam logic [7:0] PAD_BYTE = 8'h00;

    // Default frame geometry (VGA).
    localparam int FRAME_W_DEF       = 640;
    localparam int FRAME_H_DEF       = 480;
    localparam int PIX_PER_FRAME_DEF = FRAME_W_DEF * FRAME_H_DEF;

    // Memory word from camera bytes: {pad, R, G, B}.
    function automatic logic [PIX_WORD_W-1:0] pack_rgb(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {PAD_BYTE, r, g, b};
    endfunction

    // Memory word from a 24-bit generated pattern value.
    function automatic logic [PIX_WORD_W-1:0] pack_pattern(
        input logic [23:0] v
    );
        return {PAD_BYTE, v};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
//------------------------------------------------------------------------------
// sync_fifo_fwft
//   Single-clock FIFO with a registered output stage. Storage holds DEPTH
//   entries; the output register holds one more, so the total capacity is
//   DEPTH+1 words. A pushed word always lands in storage first and moves to
//   the output register on the following edge.
//
//   Handshake (o_valid/i_rdy): a word transfers on a clock edge where both
//   o_valid and i_rdy are high. While o_valid is high and i_rdy is low, o_data
//   is held and o_valid stays high. o_valid falls only after a transfer (or on
//   reset). One transfer per cycle is possible.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   i_push   in   write request for i_data
//   i_data   in   W   write data
//   o_drop   out  push this cycle is rejected (storage full, no pop)
//   i_rdy    in   consumer accepts o_data
//   o_valid  out  o_data valid
//   o_data   out  W   head word
//   o_empty  out  nothing stored, output register empty
//   o_full   out  storage full and output register occupied
//------------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_drop,
    input  logic         i_rdy,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);

    logic [W-1:0] r_mem [DEPTH];
    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;

    logic w_mem_empty;
    logic w_mem_full;
    logic w_out_load;
    logic w_mem_pop;
    logic w_mem_push;

    always_comb begin
        w_mem_empty = (r_wr_ptr == r_rd_ptr);
        w_mem_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        // Output register can take a new word when empty or being consumed.
        w_out_load  = !r_out_valid || i_rdy;
        w_mem_pop   = w_out_load && !w_mem_empty;
        // A full store still accepts a push when its head leaves this cycle.
        w_mem_push  = i_push && (!w_mem_full || w_mem_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_mem_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_mem_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_out_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
            if (w_out_load) begin
                r_out_valid <= !w_mem_empty;
            end
        end
    end

    // Storage array needs no reset; pointers define its contents.
    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_drop  = i_push && !w_mem_push;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_empty = w_mem_empty && !r_out_valid;
    assign o_full  = w_mem_full && r_out_valid;

endmodule

// File: rtl/cam_pix_packer.sv
//------------------------------------------------------------------------------
// cam_pix_packer
//   Samples a byte-serial camera stream (vsync/href qualified, bytes R,G,B),
//   assembles 24-bit pixels, pads them to 32-bit words {8'h00,R,G,B} and
//   queues them for the frame-buffer write port. Reports frame completion,
//   pixel count mismatch and FIFO overflow.
//
//   Build option: define CAM_PIX_PACKER_TST_PATT_EN to let tst_mode replace
//   the camera bytes with a per-frame incrementing 24-bit pattern.
//
//   Write handshake: a word transfers on a clock edge with wr_req && wr_rdy;
//   wr_data is held while wr_req && !wr_rdy; wr_req never drops without a
//   transfer except on reset; back-to-back transfers are allowed.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   cap_en      in   capture enable (level)
//   pix_valid   in   pix_data qualifier
//   pix_data    in   8  camera byte
//   vsync       in   high = vertical blanking
//   href        in   high = active line
//   tst_mode    in   pattern select (only with CAM_PIX_PACKER_TST_PATT_EN)
//   wr_rdy      in   downstream accepts a word
//   wr_req      out  wr_data valid
//   wr_data     out  32 {8'h00,R,G,B}
//   frame_done  out  one-cycle pulse after a frame has fully drained
//   frame_err   out  sticky: a frame's pixel count differed from PIX_PER_FRAME
//   overflow    out  sticky: a pixel was dropped on a full FIFO
//   busy        out  FSM not idle
//   dbg_state   out  2  current FSM state (cap_state_t encoding)
//------------------------------------------------------------------------------
module cam_pix_packer
    import img_cap_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int FIFO_AW       = 4,
    parameter int PIX_PER_FRAME = PIX_PER_FRAME_DEF,
    parameter int CNT_W         = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_en,
    input  logic                  pix_valid,
    input  logic [7:0]            pix_data,
    input  logic                  vsync,
    input  logic                  href,
    input  logic                  tst_mode,
    input  logic                  wr_rdy,
    output logic                  wr_req,
    output logic [PIX_WORD_W-1:0] wr_data,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  overflow,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam logic [CNT_W-1:0] LP_PPF = CNT_W'(PIX_PER_FRAME);

    cap_state_t r_state;
    cap_state_t w_state_nxt;

    logic                  r_vsync_d;
    logic                  r_vs_vld;
    logic [1:0]            r_phase;
    logic [7:0]            r_byte_r;
    logic [7:0]            r_byte_g;
    logic [CNT_W-1:0]      r_pix_cnt;
    logic                  r_push;
    logic [PIX_WORD_W-1:0] r_push_data;
    logic                  r_frame_done;
    logic                  r_frame_err;
    logic                  r_overflow;

    logic                  w_vs_fall;
    logic                  w_vs_rise;
    logic                  w_accept;
    logic                  w_pix_done;
    logic                  w_clr_flags;
    logic                  w_frame_start;
    logic                  w_drain_done;
    logic                  w_fifo_empty;
    logic                  w_drop;
    logic                  w_unused_full;
    logic [PIX_WORD_W-1:0] w_pix_word;

    // r_vs_vld masks the first cycle after reset, when r_vsync_d is not yet
    // a real sample of vsync.
    always_comb begin
        w_vs_fall  = r_vs_vld && r_vsync_d && !vsync;
        w_vs_rise  = r_vs_vld && !r_vsync_d && vsync;
        w_accept   = (r_state == S_ACTIVE) && href && pix_valid;
        w_pix_done = w_accept && (r_phase == 2'd2);
    end

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_flags   = 1'b0;
        w_frame_start = 1'b0;
        w_drain_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cap_en) begin
                    w_clr_flags = 1'b1;
                    w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!cap_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_vs_fall) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // cap_en is not looked at here: a started frame always finishes.
                if (w_vs_rise) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // r_push covers a pixel completed in the last active cycle
                // that has not reached the FIFO yet.
                if (w_fifo_empty && !r_push) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = cap_en ? S_SYNC : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Pixel word content
    //--------------------------------------------------------------------------
`ifdef CAM_PIX_PACKER_TST_PATT_EN
    logic [23:0] r_tp_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tp_cnt <= '0;
        end else if (w_frame_start) begin
            r_tp_cnt <= '0;
        end else if (w_pix_done) begin
            r_tp_cnt <= r_tp_cnt + 24'd1;
        end
    end

    always_comb begin
        w_pix_word = tst_mode ? pack_pattern(r_tp_cnt)
                              : pack_rgb(r_byte_r, r_byte_g, pix_data);
    end
`else
    logic w_unused_tst;
    assign w_unused_tst = tst_mode;

    always_comb begin
        w_pix_word = pack_rgb(r_byte_r, r_byte_g, pix_data);
    end
`endif

    //--------------------------------------------------------------------------
    // Capture datapath and status flags
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vsync_d    <= 1'b0;
            r_vs_vld     <= 1'b0;
            r_phase      <= 2'd0;
            r_byte_r     <= '0;
            r_byte_g     <= '0;
            r_pix_cnt    <= '0;
            r_push       <= 1'b0;
            r_push_data  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_vs_vld  <= 1'b1;

            // Byte phase; href low drops any partial pixel.
            if (w_frame_start) begin
                r_phase <= 2'd0;
            end else if (r_state == S_ACTIVE) begin
                if (!href) begin
                    r_phase <= 2'd0;
                end else if (pix_valid) begin
                    r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
                end
            end

            if (w_accept && (r_phase == 2'd0)) begin
                r_byte_r <= pix_data;
            end
            if (w_accept && (r_phase == 2'd1)) begin
                r_byte_g <= pix_data;
            end

            // Completed pixel is staged one cycle, then pushed.
            r_push <= w_pix_done;
            if (w_pix_done) begin
                r_push_data <= w_pix_word;
            end

            // Counts dropped pixels too; saturates at all-ones.
            if (w_frame_start) begin
                r_pix_cnt <= '0;
            end else if (w_pix_done && (r_pix_cnt != {CNT_W{1'b1}})) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end

            r_frame_done <= w_drain_done;

            if (w_clr_flags) begin
                r_frame_err <= 1'b0;
            end else if (w_drain_done && (r_pix_cnt != LP_PPF)) begin
                r_frame_err <= 1'b1;
            end

            if (w_clr_flags) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Word FIFO
    //--------------------------------------------------------------------------
    sync_fifo_fwft #(
        .W     (PIX_WORD_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .o_drop  (w_drop),
        .i_rdy   (wr_rdy),
        .o_valid (wr_req),
        .o_data  (wr_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_unused_full)
    );

    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_cam_pix_packer.sv
module tb_cam_pix_packer;

  localparam int PPF = 4;    // small frame so frame checks stay short
  localparam int CW  = 3;    // counter saturates at 7
  localparam int SAT = 7;
  localparam int CAP = 17;   // 16 storage + 1 output register

`ifdef CAM_PIX_PACKER_TST_PATT_EN
  localparam bit TP_EN = 1'b1;
`else
  localparam bit TP_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cap_en = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic        tst_mode = 1'b0;
  logic        wr_rdy = 1'b0;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic        overflow;
  logic        busy;
  logic [1:0]  dbg_state;

  cam_pix_packer #(
    .FIFO_DEPTH    (16),
    .FIFO_AW       (4),
    .PIX_PER_FRAME (PPF),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_en     (cap_en),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .vsync      (vsync),
    .href       (href),
    .tst_mode   (tst_mode),
    .wr_rdy     (wr_rdy),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_xfer = 0;

  // reference model
  logic [31:0] exp_q[$];
  int          m_cnt = 0;
  logic [23:0] m_tp = '0;
  logic        m_err = 1'b0;
  logic        m_ovf = 1'b0;
  int          rdy_mode = 0;   // 0 low, 1 high, 2 random
  bit          rand_gaps = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ready driver (sole driver of wr_rdy)
  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: wr_rdy = 1'b0;
      1: wr_rdy = 1'b1;
      default: wr_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard: a transfer happens on the coming edge when both are high
  always @(negedge clk) begin
    if (wr_req === 1'b1 && wr_rdy === 1'b1) begin
      n_xfer++;
      if (exp_q.size() == 0) check("xfer_unexpected_qsize", 32'(exp_q.size()), 32'd1);
      else check("wr_data", wr_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    if (rand_gaps) begin
      repeat ($urandom_range(0, 2)) begin
        pix_data = 8'($urandom);
        tick();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    pix_valid = 1'b1;
    pix_data  = b;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic model_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [31:0] w;
    if (m_cnt < SAT) m_cnt++;
    w = (TP_EN && tst_mode) ? {8'h00, m_tp} : {8'h00, r, g, b};
    m_tp = m_tp + 24'd1;
    if (exp_q.size() < CAP) exp_q.push_back(w);
    else m_ovf = 1'b1;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    send_byte(r); gap();
    send_byte(g); gap();
    send_byte(b);
    model_pixel(r, g, b);
    gap();
  endtask

  task automatic rand_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        href = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        href = 1'b1;
      end
      send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    m_cnt = 0;
    m_tp  = '0;
    href  = 1'b1;
  endtask

  task automatic frame_end(input string tag);
    bit got;
    got = 1'b0;
    href = 1'b0;
    tick();
    vsync = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      tick();
      if (frame_done === 1'b1) got = 1'b1;
    end
    check({tag, "_frame_done_seen"}, 32'(got), 32'd1);
    m_err = m_err | (m_cnt != PPF);
    check({tag, "_model_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'(m_err));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_state_after"}, 32'(dbg_state), cap_en ? 32'd1 : 32'd0);
    tick();
    check({tag, "_frame_done_1cyc"}, 32'(frame_done), 32'd0);
  endtask

  // re-enter capture through idle, clearing the sticky flags
  task automatic cycle_cap(input string tag);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    cap_en = 1'b1;
    tick();
    m_err = 1'b0;
    m_ovf = 1'b0;
    check({tag, "_err_cleared"}, 32'(frame_err), 32'd0);
    check({tag, "_ovf_cleared"}, 32'(overflow), 32'd0);
    check({tag, "_sync"}, 32'(dbg_state), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_w;
    int base;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    rdy_mode = 1;
    tick();
    tick();
    check("idle_hold", 32'(dbg_state), 32'd0);
    cap_en = 1'b1;
    tick();
    check("enter_sync", 32'(dbg_state), 32'd1);
    check("sync_busy", 32'(busy), 32'd1);

    // single pixel and latency
    frame_start();
    check("active_state", 32'(dbg_state), 32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);               // B sampled at edge N
    model_pixel(8'h11, 8'h22, 8'h33);
    base = n_xfer;
    check("lat_n", 32'(wr_req), 32'd0);
    tick();
    check("lat_n1", 32'(wr_req), 32'd0);
    tick();
    check("lat_n2_req", 32'(wr_req), 32'd1);
    check("lat_n2_data", wr_data, 32'h00112233);
    tick();
    check("lat_one_xfer_req", 32'(wr_req), 32'd0);
    check("lat_one_xfer_cnt", 32'(n_xfer - base), 32'd1);
    cap_en = 1'b0;                  // does not abort the frame
    tick();
    check("active_after_cap_drop", 32'(dbg_state), 32'd2);
    frame_end("f1");
    cycle_cap("f1");

    // broken line, then full pixels with random ready and gaps
    rdy_mode = 2;
    rand_gaps = 1'b1;
    frame_start();
    send_byte(8'hA1); gap();
    send_byte(8'hA2); gap();
    href = 1'b0;
    tick();
    tick();
    href = 1'b1;
    base = n_xfer;
    rand_pixels(4);
    frame_end("f2_broken");
    check("f2_xfer_cnt", 32'(n_xfer - base), 32'd4);

    // short frame, then a correct frame: error stays sticky
    frame_start();
    rand_pixels(3);
    frame_end("f3_short");
    frame_start();
    rand_pixels(4);
    cap_en = 1'b0;
    frame_end("f4_sticky");
    cycle_cap("f4");

    // counter saturation: 12 pixels must not wrap back to 4
    frame_start();
    rand_pixels(12);
    cap_en = 1'b0;
    frame_end("f5_sat");
    cycle_cap("f5");

    // backpressure and overflow
    rdy_mode = 0;
    frame_start();
    first_w = '0;
    for (int i = 0; i < 20; i++) begin
      send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
      if (i == 0) first_w = exp_q[0];
      if (i == 16) begin
        repeat (3) tick();
        check("ovf_after_17", 32'(overflow), 32'(m_ovf));
      end
      if (i == 17) begin
        repeat (3) tick();
        check("ovf_after_18", 32'(overflow), 32'd1);
      end
    end
    check("bp_wr_req", 32'(wr_req), 32'd1);
    check("bp_hold_first", wr_data, first_w);
    check("bp_model_stored", 32'(exp_q.size()), 32'd17);
    base = n_xfer;
    cap_en = 1'b0;
    rdy_mode = 1;
    frame_end("f6_bp");
    check("bp_drain_cnt", 32'(n_xfer - base), 32'd17);
    cycle_cap("f6");

    // test-pattern select (ignored in the default build)
    frame_start();
    tst_mode = 1'b1;
    rand_pixels(3);
    frame_end("f7_tp");
    tst_mode = 1'b0;

    // asynchronous reset mid-frame with words pending
    rdy_mode = 0;
    frame_start();
    rand_pixels(5);
    repeat (3) tick();
    check("pre_rst_wr_req", 32'(wr_req), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_wr_req", 32'(wr_req), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    check("arst_wr_data", wr_data, 32'd0);
    exp_q.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
    cap_en = 1'b0;
    href = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    rdy_mode = 1;
    base = n_xfer;
    repeat (10) tick();
    check("post_rst_no_xfer", 32'(n_xfer - base), 32'd0);
    check("post_rst_wr_req", 32'(wr_req), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_pix_packer.md
Name: cam_pix_packer

Overview:
- Upstream feeder for the frame buffer / RAM port 0 write path.
- Samples a byte-serial camera stream (vsync/href qualified), assembles R,G,B bytes into 24-bit pixels, and zero-pads them to 32-bit words.
- Buffers words in a small FIFO and presents them to the memory write side over a valid/ready handshake (wr_req/wr_rdy).
- Reports frame completion, pixel-count mismatch and overflow.

Parameters:
- FIFO_DEPTH, 16: FIFO entries; power of two.
- FIFO_AW, 4: log2(FIFO_DEPTH).
- PIX_PER_FRAME, 307200: expected pixels per frame (640x480).
- CNT_W, 19: pixel counter width; must satisfy 2^CNT_W > PIX_PER_FRAME.

Ports:
- clk  input  1  single system clock (CLOCK_125_p domain).
- reset  input  1  asynchronous, active-low reset.
- cap_en  input  1  capture enable; level.
- pix_valid  input  1  pix_data qualifier (one per camera byte).
- pix_data  input  8  camera byte; order R, G, B.
- vsync  input  1  high = vertical blanking.
- href  input  1  high = active line.
- tst_mode  input  1  test-pattern select (used only with TST_PATT_EN).
- wr_rdy  input  1  downstream can accept a word.
- wr_req  output  1  wr_data valid.
- wr_data  output  32  {8'h00, R, G, B}.
- frame_done  output  1  one-cycle pulse at end of frame, after drain.
- frame_err  output  1  sticky: last frame pixel count != PIX_PER_FRAME.
- overflow  output  1  sticky: a pixel was dropped because the FIFO was full.
- busy  output  1  high in any state other than S_IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0.
  - FIFO empty, byte phase 0, pixel count 0, state S_IDLE.
- FSM states and transitions:
  - S_IDLE: if cap_en == 1, clear frame_err and overflow, go to S_SYNC.
  - S_SYNC: wait for vsync 1->0 (frame start); go to S_ACTIVE with pixel count 0 and phase 0. If cap_en == 0, go to S_IDLE.
  - S_ACTIVE: accept bytes only when href && pix_valid.
    - phase 0 latches R, phase 1 latches G, phase 2 latches B; the pixel completes and phase returns to 0.
    - On vsync 0->1, go to S_DRAIN.
  - S_DRAIN: no capture. When FIFO is empty and wr_req == 0:
    - pulse frame_done for 1 cycle;
    - set frame_err if pixel count != PIX_PER_FRAME;
    - go to S_SYNC if cap_en, else S_IDLE.
- cap_en dropping in S_ACTIVE does not abort the frame; the frame completes normally.
- Edge detection uses vsync registered once inside the block. The first cycle after reset cannot produce an edge.
- href falling with phase 1 or 2: the partial pixel is discarded, phase is reset to 0, and it is not counted.
- Latency:
  - B byte sampled at edge N: word written to FIFO at edge N+1.
  - If the FIFO was empty and the output register free, wr_req is high after edge N+2.
- Handshake:
  - Transfer occurs when wr_req && wr_rdy at a clock edge.
  - wr_data is held stable while wr_req && !wr_rdy.
  - wr_req is never deasserted without a transfer (except on reset).
  - Back-to-back transfers are allowed: one word per cycle.
- FIFO: output register plus FIFO_DEPTH storage.
  - Full + push with no simultaneous pop: pixel dropped, overflow set, pixel counted.
  - Full + push with simultaneous pop: push accepted.
  - Empty: no read.
  - Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
- Pixel counter saturates at 2^CNT_W-1.

Optional Feature:
- Macro: CAM_PIX_PACKER_TST_PATT_EN.
- Defined, with tst_mode == 1 in S_ACTIVE: each completed pixel slot carries a 24-bit incrementing value instead of the camera bytes. The value starts at 24'h000000 each frame and increments per completed pixel. Framing still follows vsync/href/pix_valid.
- Undefined: tst_mode is ignored; the tst_mode port remains for a stable interface.

Decomposition:
- Shared package img_cap_pkg:
  - FSM state encoding S_IDLE/S_SYNC/S_ACTIVE/S_DRAIN (2 bits);
  - pixel word width 32;
  - pad byte 8'h00;
  - default frame geometry constants.
- One sub-module: sync_fifo_fwft. Parameterised by width and depth; push/pop/full/empty plus output register. Reusable elsewhere in the capture path.

Test Plan:
- Reset and single pixel:
  - Stimulus: reset, cap_en=1, vsync 1->0, href=1, bytes 8'h11,8'h22,8'h33 with wr_rdy=1.
  - Response: wr_data=32'h00112233 with wr_req high exactly 2 cycles after the B byte; one transfer.
- Backpressure:
  - Stimulus: wr_rdy=0; push 20 pixels.
  - Response: wr_req high and wr_data holding the first word. 17 words stored (16 FIFO + 1 output register); overflow=1 after the 18th pixel.
  - Then wr_rdy=1: exactly 17 words drain, in order.
- Short frame:
  - Stimulus: PIX_PER_FRAME=4; send 3 pixels, then vsync rises.
  - Response: frame_done pulse after the drain; frame_err=1.
  - Next frame with 4 pixels: frame_err clears only on re-entry through S_IDLE (cap_en toggle).
- Broken line:
  - Stimulus: href falls after R,G.
  - Response: no word emitted; the next R,G,B on a new line produces a correct word; pixel count unaffected by the fragment.
- Async reset mid-frame:
  - Stimulus: reset pulse with the FIFO holding 5 words and wr_req high.
  - Response: wr_req=0 immediately, FIFO empty, state S_IDLE.
- Test-pattern mode (macro defined, tst_mode=1):
  - Stimulus: 3 pixels.
  - Response: 32'h00000000, 32'h00000001, 32'h00000002.
